// File: rtl/ahb_resp_mux.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_resp_mux
//  Purpose  : Per-master-layer AHB slave select resolver and response mux.
//             Priority-resolves the decoder select to one slave, tracks the
//             data-phase owner, returns that slave's HRDATA/HREADY/HRESP and
//             implements the default slave (two-cycle ERROR for unmapped
//             active transfers) with a saturating decode-error counter.
//  Revision : 1.0  initial release
// ============================================================================
module ahb_resp_mux #(
  parameter int NUM_SLAVES    = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                             i_hclk,
  input  logic                             i_hresetn,
  input  logic [NUM_SLAVES-1:0]            i_hsel,
  input  logic [1:0]                       i_htrans,
  output logic [NUM_SLAVES-1:0]            o_hsel,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_hrdata,
  input  logic [NUM_SLAVES-1:0]            i_hreadyout,
  input  logic [NUM_SLAVES-1:0]            i_hresp,
  output logic [DATA_WIDTH-1:0]            o_hrdata,
  output logic                             o_hready,
  output logic                             o_hresp,
  output logic [ERR_CNT_WIDTH-1:0]         o_err_cnt
);

  // Data-phase owner. ERR1/ERR2 are the two cycles of the default slave's
  // ERROR response; ERR1 is only ever entered for an active (NONSEQ/SEQ)
  // transfer, so the sampled HTRANS[1] is fully captured by the state.
  typedef enum logic [1:0] {
    DP_IDLE  = 2'd0,
    DP_SLAVE = 2'd1,
    DP_ERR1  = 2'd2,
    DP_ERR2  = 2'd3
  } dp_state_t;

  localparam logic [ERR_CNT_WIDTH-1:0] C_ERR_MAX = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] C_ERR_ONE = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

  dp_state_t                 r_state;
  dp_state_t                 w_state_nxt;
  logic [NUM_SLAVES-1:0]     r_sel_dp;
  logic [ERR_CNT_WIDTH-1:0]  r_err_cnt;

  logic [NUM_SLAVES-1:0]     w_hsel_res;
  logic                      w_found;
  logic [DATA_WIDTH-1:0]     w_slv_rdata;
  logic                      w_slv_ready;
  logic                      w_slv_resp;
  logic                      w_err_entry;

  // Priority resolve: keep only the lowest-index asserted select bit.
  always_comb begin
    w_hsel_res = '0;
    w_found    = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (i_hsel[k] && !w_found) begin
        w_hsel_res[k] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign o_hsel = w_hsel_res;

  // AND-OR mux of the data-phase slave's response fields (r_sel_dp is one-hot).
  always_comb begin
    w_slv_rdata = '0;
    w_slv_ready = 1'b0;
    w_slv_resp  = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (r_sel_dp[k]) begin
        w_slv_rdata = w_slv_rdata | i_hrdata[k*DATA_WIDTH +: DATA_WIDTH];
        w_slv_ready = w_slv_ready | i_hreadyout[k];
        w_slv_resp  = w_slv_resp  | i_hresp[k];
      end
    end
  end

  // Response outputs per data-phase state, then next-state on sampling edges.
  always_comb begin
    w_state_nxt = r_state;
    w_err_entry = 1'b0;
    o_hready    = 1'b1;
    o_hresp     = 1'b0;
    o_hrdata    = '0;

    case (r_state)
      DP_SLAVE: begin
        o_hrdata = w_slv_rdata;
        o_hready = w_slv_ready;
        o_hresp  = w_slv_resp;
      end
      DP_ERR1: begin
        o_hready = 1'b0;
        o_hresp  = 1'b1;
      end
      DP_ERR2: begin
        o_hresp  = 1'b1;
      end
      default: begin
      end
    endcase

    if (r_state == DP_ERR1) begin
      w_state_nxt = DP_ERR2;
    end else if (o_hready) begin
      if (|w_hsel_res) begin
        w_state_nxt = DP_SLAVE;
      end else if (i_htrans[1]) begin
        w_state_nxt = DP_ERR1;
        w_err_entry = 1'b1;
      end else begin
        w_state_nxt = DP_IDLE;
      end
    end
  end

  // State, data-phase select and error counter registers.
  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_state   <= DP_IDLE;
      r_sel_dp  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (o_hready) begin
        r_sel_dp <= w_hsel_res;
      end
      if (w_err_entry && (r_err_cnt != C_ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + C_ERR_ONE;
      end
    end
  end

  assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire
